// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the scoreboard slot layout for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int SB_RA_W = 5;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_EXE  = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_LOAD = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HOLD  = 2'b11
    } ctrl_state_e;

    typedef struct packed {
        logic               valid;
        logic               wreg;
        logic               m2reg;
        logic [SB_RA_W-1:0] dest;
    } sb_slot_t;

    localparam int       SLOT_W     = $bits(sb_slot_t);
    localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow of the EXE, MEM and WB destinations; shifts each unfrozen cycle,
// loading either the ID instruction or an empty slot into EXE.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              insert_bubble,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic [SB_RA_W-1:0] in_dest,
    output logic [SLOT_W-1:0] exe_slot,
    output logic [SLOT_W-1:0] mem_slot,
    output logic [SLOT_W-1:0] wb_slot
);

    sb_slot_t exe_q, mem_q, wb_q;
    sb_slot_t exe_d, mem_d, wb_d;
    sb_slot_t ins;

    always_comb begin
        ins       = SLOT_EMPTY;
        ins.valid = 1'b1;
        ins.wreg  = in_wreg;
        ins.m2reg = in_m2reg;
        ins.dest  = in_dest;

        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            exe_d = insert_bubble ? SLOT_EMPTY : ins;
            mem_d = exe_q;
            wb_d  = mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign exe_slot = exe_q;
    assign mem_slot = mem_q;
    assign wb_slot  = wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage enables, bubble/flush, forwarding, stall count.
// Optional operand forwarding is enabled by defining PIPE_FWD_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = SB_RA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_m2reg,
    input  logic             e_branch_taken,
    input  logic             ext_hold,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             id_exe_bubble,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    function automatic logic src_hit(input sb_slot_t s, input logic use_src,
                                     input logic [SB_RA_W-1:0] src);
        return s.valid && s.wreg && (s.dest != '0) && use_src && (s.dest == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [SLOT_W-1:0] exe_bits, mem_bits, wb_slot_unused;
    sb_slot_t          exe_s, mem_s;
    logic              exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;
    logic              data_stall;
    ctrl_state_e       ctrl_state_q, ctrl_state_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    assign exe_s = sb_slot_t'(exe_bits);
    assign mem_s = sb_slot_t'(mem_bits);

    assign exe_hit_a = src_hit(exe_s, id_use_rs, id_rs);
    assign exe_hit_b = src_hit(exe_s, id_use_rt, id_rt);
    assign mem_hit_a = src_hit(mem_s, id_use_rs, id_rs);
    assign mem_hit_b = src_hit(mem_s, id_use_rt, id_rt);

`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fwd_pick(input logic exe_hit, input logic exe_load,
                                            input logic mem_hit, input logic mem_load);
        if (exe_hit && !exe_load) return FWD_EXE;
        if (mem_hit)              return mem_load ? FWD_LOAD : FWD_MEM;
        return FWD_REG;
    endfunction

    // Only a load still in EXE cannot be forwarded in time.
    assign data_stall = exe_s.m2reg && (exe_hit_a || exe_hit_b);
    assign fwd_a      = fwd_pick(exe_hit_a, exe_s.m2reg, mem_hit_a, mem_s.m2reg);
    assign fwd_b      = fwd_pick(exe_hit_b, exe_s.m2reg, mem_hit_b, mem_s.m2reg);
`else
    logic load_bits_unused;

    assign load_bits_unused = exe_s.m2reg ^ mem_s.m2reg;
    assign data_stall = exe_hit_a || exe_hit_b || mem_hit_a || mem_hit_b;
    assign fwd_a      = FWD_REG;
    assign fwd_b      = FWD_REG;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_state_q   <= ST_RUN;
            stall_cycles_q <= '0;
        end else begin
            ctrl_state_q   <= ctrl_state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // The "next state" is the action taken this cycle, in priority order.
    always_comb begin
        ctrl_state_d = ST_RUN;
        if (ext_hold)            ctrl_state_d = ST_HOLD;
        else if (e_branch_taken) ctrl_state_d = ST_FLUSH;
        else if (data_stall)     ctrl_state_d = ST_STALL;

        stall_cycles_d = stall_cycles_q;
        if (ctrl_state_d == ST_STALL) stall_cycles_d = sat_inc(stall_cycles_q);
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_exe_en     = 1'b1;
        exe_mem_en    = 1'b1;
        mem_wb_en     = 1'b1;
        id_exe_bubble = 1'b0;
        if_id_flush   = 1'b0;
        unique case (ctrl_state_d)
            ST_HOLD: begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                id_exe_en  = 1'b0;
                exe_mem_en = 1'b0;
                mem_wb_en  = 1'b0;
            end
            ST_FLUSH: begin
                id_exe_bubble = 1'b1;
                if_id_flush   = 1'b1;
            end
            ST_STALL: begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_exe_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    hazard_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .freeze        (ctrl_state_d == ST_HOLD),
        .insert_bubble ((ctrl_state_d == ST_FLUSH) || (ctrl_state_d == ST_STALL)),
        .in_wreg       (id_wreg),
        .in_m2reg      (id_m2reg),
        .in_dest       (id_dest),
        .exe_slot      (exe_bits),
        .mem_slot      (mem_bits),
        .wb_slot       (wb_slot_unused)
    );

    assign ctrl_state   = ctrl_state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations follow PIPE_FWD_EN like the RTL does.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wreg;
        logic [4:0] dest;
        logic       m2r;
    } ins_t;

    typedef struct {
        string       nm;
        logic [10:0] ctl;
        logic [1:0]  st;
        int          cnt;
    } exp_t;

    //                         rs     rt    urs   urt   wreg  dest   m2r
    localparam ins_t NOP  = {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
    localparam ins_t LW3  = {5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1};
    localparam ins_t ADD4 = {5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0};
    localparam ins_t ADD5 = {5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0};
    localparam ins_t SUB6 = {5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0};
    localparam ins_t OR7  = {5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0};
    localparam ins_t ADD0 = {5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
    localparam ins_t USE0 = {5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0};

    // {ext_hold, e_branch_taken, rst}
    localparam logic [2:0] Z = 3'b000, H = 3'b100, B = 3'b010, R = 3'b001;
    localparam logic [4:0] ALL = 5'b11111, STL = 5'b00111, OFF = 5'b00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic        e_branch_taken, ext_hold;
    logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic        id_exe_bubble, if_id_flush;
    logic [1:0]  fwd_a, fwd_b, ctrl_state;
    logic [15:0] stall_cycles;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_wreg        (id_wreg),
        .id_dest        (id_dest),
        .id_m2reg       (id_m2reg),
        .e_branch_taken (e_branch_taken),
        .ext_hold       (ext_hold),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_exe_en      (id_exe_en),
        .exe_mem_en     (exe_mem_en),
        .mem_wb_en      (mem_wb_en),
        .id_exe_bubble  (id_exe_bubble),
        .if_id_flush    (if_id_flush),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .ctrl_state     (ctrl_state),
        .stall_cycles   (stall_cycles)
    );

    task automatic drive(input ins_t i, input logic [2:0] hbr);
        id_rs          = i.rs;
        id_rt          = i.rt;
        id_use_rs      = i.urs;
        id_use_rt      = i.urt;
        id_wreg        = i.wreg;
        id_dest        = i.dest;
        id_m2reg       = i.m2r;
        ext_hold       = hbr[2];
        e_branch_taken = hbr[1];
        rst            = hbr[0];
    endtask

    // One ID cycle: wait for the edge, drive inputs, queue what the monitor must see.
    task automatic cyc(input string nm, input ins_t i, input logic [2:0] hbr,
                       input logic [4:0] en, input logic bub, input logic fl,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] st, input int cnt);
        exp_t x;
        @(posedge clk);
        #1;
        drive(i, hbr);
        x.nm  = nm;
        x.ctl = {en, bub, fl, fa, fb};
        x.st  = st;
        x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, id_exe_bubble,
                 if_id_flush, fwd_a, fwd_b} === e.ctl) n_pass++;
            else $display("FAIL %s ctl: got %b want %b", e.nm,
                          {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                           id_exe_bubble, if_id_flush, fwd_a, fwd_b}, e.ctl);
            n_checks++;
            if (ctrl_state === e.st) n_pass++;
            else $display("FAIL %s ctrl_state: got %b want %b", e.nm, ctrl_state, e.st);
            n_checks++;
            if (stall_cycles === e.cnt[15:0]) n_pass++;
            else $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, stall_cycles, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(NOP, R);
        @(posedge clk);
        cyc("reset",   NOP,  R, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 0);
`ifdef PIPE_FWD_EN
        cyc("lu_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 0);
        cyc("lu_stl",  ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd0, 0);
        cyc("lu_fwd",  ADD4, Z, ALL, 0, 0, 2'b11, 2'b00, 2'd1, 1);
        cyc("lu_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("alu_p",   ADD5, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("alu_exe", SUB6, Z, ALL, 0, 0, 2'b01, 2'b01, 2'd0, 1);
        cyc("alu_mem", OR7,  Z, ALL, 0, 0, 2'b10, 2'b00, 2'd0, 1);
        cyc("r0_p",    ADD0, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("r0_use",  USE0, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("nop1",    NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("yng_p1",  ADD5, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("yng_p2",  ADD5, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("yng_use", SUB6, Z, ALL, 0, 0, 2'b01, 2'b01, 2'd0, 1);
        cyc("nop2",    NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("nop3",    NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("br_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("br_fl",   ADD4, B, ALL, 1, 1, 2'b00, 2'b00, 2'd0, 1);
        cyc("br_aft",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd2, 1);
        cyc("br_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("hd_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("hd_1",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd0, 1);
        cyc("hd_2",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd3, 1);
        cyc("hd_3",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd3, 1);
        cyc("hd_stl",  ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd3, 1);
        cyc("hd_fwd",  ADD4, Z, ALL, 0, 0, 2'b11, 2'b00, 2'd1, 2);
        cyc("hd_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("rs_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("rs_stl",  ADD4, R, STL, 1, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("rs_aft",  ADD4, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 0);
`else
        cyc("lu_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 0);
        cyc("lu_stl1", ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd0, 0);
        cyc("lu_stl2", ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd1, 1);
        cyc("lu_go",   ADD4, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd1, 2);
        cyc("lu_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("alu_p",   ADD5, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("alu_st1", SUB6, Z, STL, 1, 0, 2'b00, 2'b00, 2'd0, 2);
        cyc("alu_st2", SUB6, Z, STL, 1, 0, 2'b00, 2'b00, 2'd1, 3);
        cyc("alu_go",  SUB6, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd1, 4);
        cyc("alu_nxt", OR7,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("r0_p",    ADD0, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("r0_use",  USE0, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("nop1",    NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("br_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("br_fl",   ADD4, B, ALL, 1, 1, 2'b00, 2'b00, 2'd0, 4);
        cyc("br_aft",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd2, 4);
        cyc("br_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("hd_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("hd_1",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd0, 4);
        cyc("hd_2",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd3, 4);
        cyc("hd_3",    ADD4, H, OFF, 0, 0, 2'b00, 2'b00, 2'd3, 4);
        cyc("hd_stl1", ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd3, 4);
        cyc("hd_stl2", ADD4, Z, STL, 1, 0, 2'b00, 2'b00, 2'd1, 5);
        cyc("hd_go",   ADD4, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd1, 6);
        cyc("hd_nop",  NOP,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 6);
        cyc("rs_lw",   LW3,  Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 6);
        cyc("rs_stl",  ADD4, R, STL, 1, 0, 2'b00, 2'b00, 2'd0, 6);
        cyc("rs_aft",  ADD4, Z, ALL, 0, 0, 2'b00, 2'b00, 2'd0, 0);
`endif
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
